// File: rtl/somador_completo_reg_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands; the slave (adder) returns the registered sum.
interface somador_completo_reg_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             in_valid;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;

    modport master (
        output A, B, Cin, in_valid,
        input  S, Cout, out_valid
    );

    modport slave (
        input  A, B, Cin, in_valid,
        output S, Cout, out_valid
    );
endinterface

// File: rtl/somador_completo_reg.sv
// Registered N-bit adder: ripple chain of 1-bit full-adder cells feeding an output register.
// {Cout,S} = A + B + Cin appears one cycle after in_valid; S/Cout hold while in_valid is low.
module somador_completo_reg #(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    somador_completo_reg_if.slave   bus
);

    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             out_valid_q;

    // Carry is walked through a local variable so each cell sees the previous cell's carry-out.
    always_comb begin : ripple
        logic c;
        s_d = '0;
        c   = bus.Cin;
        for (int i = 0; i < WIDTH; i++) begin
            s_d[i] = bus.A[i] ^ bus.B[i] ^ c;
            c      = (bus.A[i] & bus.B[i]) | (c & (bus.A[i] ^ bus.B[i]));
        end
        cout_d = c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
            end
        end
    end

    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_somador_completo_reg.sv
// Scoreboard bench for somador_completo_reg at WIDTH 1, 4 and 8.
// Stimulus pushes A+B+Cin into a per-width queue; negedge monitors pop and compare on out_valid.
module tb_somador_completo_reg;

    logic clk;
    logic rst;

    int tests;
    int fails;

    int q1[$];
    int q4[$];
    int q8[$];

    somador_completo_reg_if #(.WIDTH(1)) if1 ();
    somador_completo_reg_if #(.WIDTH(4)) if4 ();
    somador_completo_reg_if #(.WIDTH(8)) if8 ();

    somador_completo_reg #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    somador_completo_reg #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    somador_completo_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition of the operands.
    function automatic int ref_sum(input int a, input int b, input int c);
        return a + b + c;
    endfunction

    always @(negedge clk) begin
        if (if1.out_valid === 1'b1) begin
            if (q1.size() == 0) chk("w1 unexpected out_valid", 32'd1, 32'd0);
            else chk("w1 {Cout,S}", 32'({if1.Cout, if1.S}), 32'(q1.pop_front()));
        end
        if (if4.out_valid === 1'b1) begin
            if (q4.size() == 0) chk("w4 unexpected out_valid", 32'd1, 32'd0);
            else chk("w4 {Cout,S}", 32'({if4.Cout, if4.S}), 32'(q4.pop_front()));
        end
        if (if8.out_valid === 1'b1) begin
            if (q8.size() == 0) chk("w8 unexpected out_valid", 32'd1, 32'd0);
            else chk("w8 {Cout,S}", 32'({if8.Cout, if8.S}), 32'(q8.pop_front()));
        end
    end

    task automatic idle_all();
        if1.in_valid = 1'b0;
        if4.in_valid = 1'b0;
        if8.in_valid = 1'b0;
    endtask

    task automatic drive1(input int a, input int b, input int c);
        @(posedge clk);
        #1;
        idle_all();
        if1.A = 1'(a); if1.B = 1'(b); if1.Cin = 1'(c); if1.in_valid = 1'b1;
        q1.push_back(ref_sum(a, b, c));
    endtask

    task automatic drive4(input int a, input int b, input int c);
        @(posedge clk);
        #1;
        idle_all();
        if4.A = 4'(a); if4.B = 4'(b); if4.Cin = 1'(c); if4.in_valid = 1'b1;
        q4.push_back(ref_sum(a, b, c));
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        idle_all();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        if1.A = '0; if1.B = '0; if1.Cin = 1'b0; if1.in_valid = 1'b0;
        if4.A = '0; if4.B = '0; if4.Cin = 1'b0; if4.in_valid = 1'b0;
        if8.A = '0; if8.B = '0; if8.Cin = 1'b0; if8.in_valid = 1'b0;

        #3;
        chk("reset w1 S", 32'(if1.S), 32'd0);
        chk("reset w1 Cout", 32'(if1.Cout), 32'd0);
        chk("reset w1 out_valid", 32'(if1.out_valid), 32'd0);
        chk("reset w4 out_valid", 32'(if4.out_valid), 32'd0);
        chk("reset w8 {Cout,S}", 32'({if8.Cout, if8.S}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // exhaustive single-bit cell
        for (int i = 0; i < 8; i++) drive1((i >> 2) & 1, (i >> 1) & 1, i & 1);
        idle_cycle();

        // full ripple, alternating bits, wrap, zero
        drive4(15, 0, 1);
        drive4(5, 10, 0);
        drive4(15, 15, 1);
        drive4(0, 0, 0);
        idle_cycle();

        // hold: S=7 captured, then new operands without in_valid
        drive4(3, 4, 0);
        @(posedge clk);
        #1;
        if4.A = 4'h9; if4.B = 4'h6; if4.in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("hold w4 S", 32'(if4.S), 32'd7);
        chk("hold w4 out_valid", 32'(if4.out_valid), 32'd0);

        // async reset between edges discards a freshly captured result
        drive1(1, 0, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        q1.delete(); q4.delete(); q8.delete();
        idle_all();
        #1;
        chk("async rst w1 S", 32'(if1.S), 32'd0);
        chk("async rst w1 Cout", 32'(if1.Cout), 32'd0);
        chk("async rst w1 out_valid", 32'(if1.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rst held w1 out_valid", 32'(if1.out_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("post-release idle w1 out_valid", 32'(if1.out_valid), 32'd0);
        drive1(1, 1, 0);
        idle_cycle();

        // randomised WIDTH=8 stream with sparse bubbles
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic       c;
            logic       v;
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            v = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            if8.A = a; if8.B = b; if8.Cin = c; if8.in_valid = v;
            if (v) q8.push_back(ref_sum(int'(a), int'(b), int'(c)));
        end
        idle_cycle();
        repeat (3) @(posedge clk);
        #2;

        chk("w1 results outstanding", 32'(q1.size()), 32'd0);
        chk("w4 results outstanding", 32'(q4.size()), 32'd0);
        chk("w8 results outstanding", 32'(q8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
